// File: rtl/usb_out_ep_fifo.sv
// usb_out_ep_fifo: byte FIFO between the USB RX packet handler and the OUT
// endpoint consumer. Packets are written speculatively at wr_ptr and only
// become readable once committed (cm_ptr) by a good end-of-packet; aborted,
// overflowing or oversize packets roll wr_ptr back to cm_ptr. rx_nak is
// raised while a max-size packet could not fit in the uncommitted space.
// Optional feature macro: USB_OUT_FIFO_STATS_EN enables the saturating
// dropped-packet counter on drop_count; otherwise drop_count reads 8'h00.
module usb_out_ep_fifo #(
  parameter int DEPTH   = 64,
  parameter int MAX_PKT = 32,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pkt_start,
  input  logic       rx_data_put,
  input  logic [7:0] rx_data,
  input  logic       rx_pkt_end,
  input  logic       rx_pkt_abort,
  output logic       rx_nak,
  output logic       out_ep_req,
  input  logic       out_ep_grant,
  output logic       out_ep_data_avail,
  input  logic       out_ep_data_get,
  output logic [7:0] out_ep_data,
  output logic       out_ep_acked,
  output logic [7:0] drop_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] MAX_P   = (ADDR_W+1)'(MAX_PKT);
  localparam logic [ADDR_W:0] ONE_P   = (ADDR_W+1)'(1);

  logic [1:0]      state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] cm_ptr_q, cm_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            avail_q, avail_d;
  logic            nak_q, nak_d;
  logic            acked_q, acked_d;
  logic [7:0]      data_q, data_d;

  logic [7:0]        mem [DEPTH];
  logic              wr_en;
  logic              commit;
  logic              full;
  logic              oversize;
  logic              pop;
  logic [ADDR_W:0]   committed_d;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  // Occupancy flags from the current pointers; the pop guard uses the live
  // comparison so a get can never run past the committed region.
  always_comb begin
    full     = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    oversize = (wr_ptr_q - cm_ptr_q) == MAX_P;
    pop      = out_ep_data_get && out_ep_grant && (cm_ptr_q != rd_ptr_q);
    wr_addr  = wr_ptr_q[ADDR_W-1:0];
  end

  // Packet FSM: a new start always abandons the current packet first, then
  // abort beats end, and a rejected put discards the whole packet.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    wr_en    = 1'b0;
    commit   = 1'b0;
    if (rx_pkt_start) begin
      wr_ptr_d = cm_ptr_q;
      state_d  = nak_q ? ST_DROP : ST_RECV;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_RECV: begin
          if (rx_pkt_abort) begin
            wr_ptr_d = cm_ptr_q;
            state_d  = ST_IDLE;
          end else if (rx_data_put && (full || oversize)) begin
            wr_ptr_d = cm_ptr_q;
            state_d  = rx_pkt_end ? ST_IDLE : ST_DROP;
          end else begin
            if (rx_data_put) begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + ONE_P;
            end
            if (rx_pkt_end) begin
              cm_ptr_d = wr_ptr_d;
              commit   = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (rx_pkt_end || rx_pkt_abort) begin
            wr_ptr_d = cm_ptr_q;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Read side and registered status; the head read forwards a same-cycle
  // write so a byte committed into an empty FIFO is visible right away.
  always_comb begin
    rd_ptr_d    = pop ? (rd_ptr_q + ONE_P) : rd_ptr_q;
    rd_addr     = rd_ptr_d[ADDR_W-1:0];
    committed_d = cm_ptr_d - rd_ptr_d;
    avail_d     = cm_ptr_d != rd_ptr_d;
    nak_d       = (DEPTH_P - committed_d) < MAX_P;
    acked_d     = commit;
    data_d      = data_q;
    if (avail_d) begin
      data_d = (wr_en && (wr_addr == rd_addr)) ? rx_data : mem[rd_addr];
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
      rd_ptr_q <= '0;
      avail_q  <= 1'b0;
      nak_q    <= 1'b0;
      acked_q  <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      avail_q  <= avail_d;
      nak_q    <= nak_d;
      acked_q  <= acked_d;
      data_q   <= data_d;
    end
  end

  // Payload storage; contents are meaningful only between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= rx_data;
    end
  end

  assign rx_nak            = nak_q;
  assign out_ep_data_avail = avail_q;
  assign out_ep_req        = avail_q;
  assign out_ep_data       = data_q;
  assign out_ep_acked      = acked_q;

`ifdef USB_OUT_FIFO_STATS_EN
  logic       drop_event;
  logic [7:0] drop_count_q, drop_count_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    if (inc && (v != 8'hFF)) begin
      return v + 8'd1;
    end
    return v;
  endfunction

  // One drop event per packet that is discarded rather than committed.
  always_comb begin
    drop_event = ((state_q == ST_RECV) && (rx_pkt_start || rx_pkt_abort)) ||
                 ((state_q == ST_RECV) && !rx_pkt_start && !rx_pkt_abort &&
                  rx_data_put && (full || oversize) && rx_pkt_end) ||
                 ((state_q == ST_DROP) && (rx_pkt_start || rx_pkt_end || rx_pkt_abort));
    drop_count_d = sat_inc8(drop_count_q, drop_event);
  end

  // Saturating dropped-packet counter, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_q <= 8'h00;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_usb_out_ep_fifo.sv
// Directed bench for usb_out_ep_fifo (DEPTH=64, MAX_PKT=32).
module tb_usb_out_ep_fifo;

`ifdef USB_OUT_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_pkt_start = 1'b0;
  logic       rx_data_put = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_pkt_end = 1'b0;
  logic       rx_pkt_abort = 1'b0;
  logic       rx_nak;
  logic       out_ep_req;
  logic       out_ep_grant = 1'b0;
  logic       out_ep_data_avail;
  logic       out_ep_data_get = 1'b0;
  logic [7:0] out_ep_data;
  logic       out_ep_acked;
  logic [7:0] drop_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_drop = 0;

  usb_out_ep_fifo #(.DEPTH(64), .MAX_PKT(32)) dut (
    .clk(clk), .reset(reset),
    .rx_pkt_start(rx_pkt_start), .rx_data_put(rx_data_put), .rx_data(rx_data),
    .rx_pkt_end(rx_pkt_end), .rx_pkt_abort(rx_pkt_abort), .rx_nak(rx_nak),
    .out_ep_req(out_ep_req), .out_ep_grant(out_ep_grant),
    .out_ep_data_avail(out_ep_data_avail), .out_ep_data_get(out_ep_data_get),
    .out_ep_data(out_ep_data), .out_ep_acked(out_ep_acked), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pkt_start();
    rx_pkt_start = 1'b1; tick(); rx_pkt_start = 1'b0;
  endtask

  task automatic put(input logic [7:0] b);
    rx_data_put = 1'b1; rx_data = b; tick(); rx_data_put = 1'b0;
  endtask

  task automatic pkt_end();
    rx_pkt_end = 1'b1; tick(); rx_pkt_end = 1'b0;
  endtask

  task automatic pkt_abort();
    rx_pkt_abort = 1'b1; tick(); rx_pkt_abort = 1'b0;
  endtask

  task automatic pop_n(input int n);
    out_ep_grant = 1'b1; out_ep_data_get = 1'b1;
    for (int i = 0; i < n; i++) tick();
    out_ep_grant = 1'b0; out_ep_data_get = 1'b0;
  endtask

  function automatic logic [31:0] exp_dc();
    return STATS ? 32'(exp_drop) : 32'h0;
  endfunction

  initial begin
    // Reset values
    reset = 1'b1;
    tick(); tick();
    chk("rst_avail", 32'(out_ep_data_avail), 0);
    chk("rst_req",   32'(out_ep_req), 0);
    chk("rst_nak",   32'(rx_nak), 0);
    chk("rst_data",  32'(out_ep_data), 0);
    chk("rst_acked", 32'(out_ep_acked), 0);
    chk("rst_drop",  32'(drop_count), 0);
    reset = 1'b0;
    tick();

    // Basic packet 01,10,00,04 then drain
    pkt_start();
    put(8'h01); put(8'h10); put(8'h00); put(8'h04);
    pkt_end();
    chk("a_acked", 32'(out_ep_acked), 1);
    chk("a_avail", 32'(out_ep_data_avail), 1);
    chk("a_req",   32'(out_ep_req), 1);
    chk("a_head",  32'(out_ep_data), 32'h01);
    tick();
    chk("a_acked_pulse", 32'(out_ep_acked), 0);
    out_ep_grant = 1'b1; out_ep_data_get = 1'b1;
    tick(); chk("a_pop1", 32'(out_ep_data), 32'h10);
    tick(); chk("a_pop2", 32'(out_ep_data), 32'h00);
    tick(); chk("a_pop3", 32'(out_ep_data), 32'h04);
    chk("a_pop3_avail", 32'(out_ep_data_avail), 1);
    tick(); chk("a_pop4_avail", 32'(out_ep_data_avail), 0);
    chk("a_pop4_data", 32'(out_ep_data), 32'h04);
    tick(); chk("empty_get_data", 32'(out_ep_data), 32'h04);
    chk("empty_get_rd", 32'(dut.rd_ptr_q), 4);
    out_ep_grant = 1'b0; out_ep_data_get = 1'b0;

    // Abort rolls back
    pkt_start();
    put(8'hAA); put(8'hBB); put(8'hCC);
    pkt_abort();
    exp_drop++;
    chk("ab_avail", 32'(out_ep_data_avail), 0);
    chk("ab_acked", 32'(out_ep_acked), 0);
    chk("ab_wr",    32'(dut.wr_ptr_q), 4);
    chk("ab_cm",    32'(dut.cm_ptr_q), 4);
    chk("ab_drop",  32'(drop_count), exp_dc());
    pkt_start(); put(8'h5A); pkt_end();
    chk("rb_head", 32'(out_ep_data), 32'h5A);
    chk("rb_avail", 32'(out_ep_data_avail), 1);
    pop_n(1);
    chk("rb_empty", 32'(out_ep_data_avail), 0);

    // Two 32-byte packets fill the FIFO and raise rx_nak
    pkt_start();
    for (int i = 0; i < 32; i++) put(8'h80 + 8'(i));
    pkt_end();
    chk("f1_nak",  32'(rx_nak), 0);
    chk("f1_head", 32'(out_ep_data), 32'h80);
    pkt_start();
    for (int i = 0; i < 32; i++) put(8'h40 + 8'(i));
    pkt_end();
    chk("f2_nak",   32'(rx_nak), 1);
    chk("f2_avail", 32'(out_ep_data_avail), 1);
    chk("f2_head",  32'(out_ep_data), 32'h80);
    pkt_start(); put(8'hEE); put(8'hEF); pkt_end();
    exp_drop++;
    chk("nk_acked", 32'(out_ep_acked), 0);
    chk("nk_wr",    32'(dut.wr_ptr_q), 69);
    chk("nk_cm",    32'(dut.cm_ptr_q), 69);
    chk("nk_drop",  32'(drop_count), exp_dc());
    pop_n(1);
    chk("p1_nak",  32'(rx_nak), 1);
    chk("p1_data", 32'(out_ep_data), 32'h81);
    pop_n(31);
    chk("p32_nak",  32'(rx_nak), 0);
    chk("p32_data", 32'(out_ep_data), 32'h40);
    pop_n(32);
    chk("p64_avail", 32'(out_ep_data_avail), 0);
    chk("p64_data",  32'(out_ep_data), 32'h5F);

    // 33-byte packet is dropped
    pkt_start();
    for (int i = 0; i < 33; i++) put(8'h20 + 8'(i));
    pkt_end();
    exp_drop++;
    chk("os_acked", 32'(out_ep_acked), 0);
    chk("os_avail", 32'(out_ep_data_avail), 0);
    chk("os_wr",    32'(dut.wr_ptr_q), 69);
    chk("os_cm",    32'(dut.cm_ptr_q), 69);
    chk("os_data",  32'(out_ep_data), 32'h5F);
    chk("os_drop",  32'(drop_count), exp_dc());

    // Get without grant is ignored; zero-length packet still acks
    pkt_start(); put(8'h77); pkt_end();
    chk("ng_head", 32'(out_ep_data), 32'h77);
    out_ep_data_get = 1'b1; tick(); tick(); out_ep_data_get = 1'b0;
    chk("ng_rd",    32'(dut.rd_ptr_q), 69);
    chk("ng_avail", 32'(out_ep_data_avail), 1);
    chk("ng_data",  32'(out_ep_data), 32'h77);
    pkt_start(); pkt_end();
    chk("zl_acked", 32'(out_ep_acked), 1);
    chk("zl_cm",    32'(dut.cm_ptr_q), 70);

    // Reset mid-packet with 10 committed bytes
    pkt_start();
    for (int i = 0; i < 9; i++) put(8'h90 + 8'(i));
    pkt_end();
    chk("pre_cm", 32'(dut.cm_ptr_q), 79);
    pkt_start(); put(8'hD1); put(8'hD2);
    reset = 1'b1;
    #1;
    chk("mr_avail", 32'(out_ep_data_avail), 0);
    chk("mr_data",  32'(out_ep_data), 0);
    chk("mr_nak",   32'(rx_nak), 0);
    chk("mr_acked", 32'(out_ep_acked), 0);
    chk("mr_drop",  32'(drop_count), 0);
    chk("mr_state", 32'(dut.state_q), 0);
    tick();
    chk("mr_edge_avail", 32'(out_ep_data_avail), 0);
    reset = 1'b0;
    tick();
    pkt_start(); put(8'h12); pkt_end();
    chk("post_head", 32'(out_ep_data), 32'h12);
    chk("post_rd",   32'(dut.rd_ptr_q), 0);
    chk("post_cm",   32'(dut.cm_ptr_q), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
